// File: rtl/hs_byte_packer.sv
// Packs BEATS consecutive bytes little-endian into one registered valid/ready word.
// A last flag flushes a partial word; optional word counter under PACKER_STAT_EN.
module hs_byte_packer #(
    parameter int BEATS = 4,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_pre_i,
    input  logic [DW-1:0]         data_pre_i,
    input  logic                  last_pre_i,
    output logic                  ready_pre_o,
    output logic                  valid_post_o,
    output logic [BEATS*DW-1:0]   data_post_o,
    output logic [BEATS-1:0]      keep_post_o,
    output logic                  last_post_o,
    input  logic                  ready_post_i
`ifdef PACKER_STAT_EN
    ,
    output logic [15:0]           stat_words_o
`endif
);
    localparam int IW = $clog2(BEATS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS-1);

    logic [BEATS-2:0][DW-1:0] acc;
    logic [IW-1:0]            idx;
    logic                     accept;
    logic                     complete;
    logic [BEATS-1:0][DW-1:0] word_nxt;
    logic [BEATS-1:0]         keep_nxt;

    // Combinational ready_post_i -> ready_pre_o gives full throughput under no backpressure.
    assign ready_pre_o = !valid_post_o || ready_post_i;
    assign accept      = valid_pre_i && ready_pre_o;
    assign complete    = accept && ((idx == LAST_IDX) || last_pre_i);

    for (genvar k = 0; k < BEATS; k++) begin : g_lane
        localparam logic [IW-1:0] K = IW'(k);
        if (k == 0) begin : g_keep0
            assign keep_nxt[k] = 1'b1;
        end else begin : g_keepn
            assign keep_nxt[k] = (K <= idx);
        end
        if (k < BEATS-1) begin : g_acc
            assign word_nxt[k] = (K == idx) ? data_pre_i :
                                 (K <  idx) ? acc[k]     : '0;
        end else begin : g_top
            assign word_nxt[k] = (K == idx) ? data_pre_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_post_o <= 1'b0;
            data_post_o  <= '0;
            keep_post_o  <= '0;
            last_post_o  <= 1'b0;
            idx          <= '0;
            acc          <= '0;
        end else begin
            if (complete) begin
                valid_post_o <= 1'b1;
                data_post_o  <= word_nxt;
                keep_post_o  <= keep_nxt;
                last_post_o  <= last_pre_i;
                idx          <= '0;
                acc          <= '0;
            end else begin
                // Drain only clears valid; payload is left as-is.
                if (ready_post_i)
                    valid_post_o <= 1'b0;
                if (accept) begin
                    idx <= idx + IW'(1);
                    for (int k = 0; k < BEATS-1; k++)
                        if (idx == IW'(k))
                            acc[k] <= data_pre_i;
                end
            end
        end
    end

`ifdef PACKER_STAT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stat_words_o <= '0;
        else if (valid_post_o && ready_post_i)
            stat_words_o <= stat_words_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hs_byte_packer.sv
// Randomized + directed bench for hs_byte_packer against a byte-queue reference model.
module tb_hs_byte_packer;
    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_pre_i;
    logic [7:0]  data_pre_i;
    logic        last_pre_i;
    logic        ready_pre_o;
    logic        valid_post_o;
    logic [31:0] data_post_o;
    logic [3:0]  keep_post_o;
    logic        last_post_o;
    logic        ready_post_i;
`ifdef PACKER_STAT_EN
    logic [15:0] stat_words_o;
`endif

    hs_byte_packer #(.BEATS(BEATS), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .data_pre_i   (data_pre_i),
        .last_pre_i   (last_pre_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .keep_post_o  (keep_post_o),
        .last_post_o  (last_post_o),
        .ready_post_i (ready_post_i)
`ifdef PACKER_STAT_EN
        ,
        .stat_words_o (stat_words_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending bytes of the current word plus the visible output word.
    logic [7:0]  m_pend[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [15:0] m_stat;

    logic [31:0] dut_xfer[$];
    logic        last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic acc_ok;
        logic done;
        if (rst) begin
            m_pend.delete();
            m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0; m_stat = '0;
        end else begin
            acc_ok = valid_pre_i && (!m_valid || ready_post_i);
            if (m_valid && ready_post_i) m_stat = m_stat + 16'd1;
            done = acc_ok && ((m_pend.size() == BEATS-1) || last_pre_i);
            if (done) begin
                m_pend.push_back(data_pre_i);
                m_data = '0;
                foreach (m_pend[k]) m_data = m_data | (32'(m_pend[k]) << (8*k));
                m_keep = 4'((1 << m_pend.size()) - 1);
                m_last = last_pre_i;
                m_valid = 1'b1;
                m_pend.delete();
            end else begin
                if (ready_post_i) m_valid = 1'b0;
                if (acc_ok) m_pend.push_back(data_pre_i);
            end
        end
    endtask

    task automatic compare();
        chk("valid", 32'(valid_post_o), 32'(m_valid));
        chk("data",  data_post_o,       m_data);
        chk("keep",  32'(keep_post_o),  32'(m_keep));
        chk("last",  32'(last_post_o),  32'(m_last));
        chk("ready_pre", 32'(ready_pre_o), 32'(!m_valid || ready_post_i));
`ifdef PACKER_STAT_EN
        chk("stat", 32'(stat_words_o), 32'(m_stat));
`endif
    endtask

    // Drive one cycle's inputs, clock it, update model, compare on the falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic l, input logic rdy);
        rst = r; valid_pre_i = v; data_pre_i = d; last_pre_i = l; ready_post_i = rdy;
        #1;
        last_acc = v && ready_pre_o && !r;
        if (valid_post_o && ready_post_i && !r) dut_xfer.push_back(data_post_o);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    initial begin
        int b;
        int guard;
        rst = 1'b1; valid_pre_i = 1'b0; data_pre_i = '0; last_pre_i = 1'b0; ready_post_i = 1'b0;
        @(negedge clk);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_valid", 32'(valid_post_o), 32'h0);
        chk("rst_data",  data_post_o,       32'h0);
        chk("rst_keep",  32'(keep_post_o),  32'h0);

        // Full word, always ready
        step(0, 1, 8'h11, 0, 1);
        step(0, 1, 8'h22, 0, 1);
        step(0, 1, 8'h33, 0, 1);
        step(0, 1, 8'h44, 0, 1);
        chk("full_valid", 32'(valid_post_o), 32'h1);
        chk("full_data",  data_post_o,       32'h44332211);
        chk("full_keep",  32'(keep_post_o),  32'hF);
        chk("full_last",  32'(last_post_o),  32'h0);
        step(0, 0, 8'h00, 0, 1);
        chk("drain_valid", 32'(valid_post_o), 32'h0);
        chk("drain_hold",  data_post_o,       32'h44332211);

        // Early flush, then next byte in lane 0
        step(0, 1, 8'hAA, 0, 1);
        step(0, 1, 8'hBB, 1, 1);
        chk("flush_data", data_post_o,      32'h0000BBAA);
        chk("flush_keep", 32'(keep_post_o), 32'h3);
        chk("flush_last", 32'(last_post_o), 32'h1);
        step(0, 1, 8'hCC, 1, 1);
        chk("lane0_data", data_post_o,      32'h000000CC);
        step(0, 1, 8'h5A, 1, 1);
        chk("single_data", data_post_o,      32'h0000005A);
        chk("single_keep", 32'(keep_post_o), 32'h1);
        step(0, 0, 8'h00, 0, 1);

        // Backpressure
        for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 1);
        dut_xfer.delete();
        b = 5;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'(b), 0, 0);
            chk("stall_ready", 32'(ready_pre_o), 32'h0);
            chk("stall_data",  data_post_o,      32'h04030201);
            chk("stall_valid", 32'(valid_post_o), 32'h1);
        end
        guard = 0;
        while (b <= 12 && guard < 50) begin
            step(0, 1, 8'(b), 0, 1);
            if (last_acc) b++;
            guard++;
        end
        chk("bp_timeout", 32'(b), 32'd13);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
        chk("bp_count", 32'(dut_xfer.size()), 32'd3);
        if (dut_xfer.size() == 3) begin
            chk("bp_w0", dut_xfer[0], 32'h04030201);
            chk("bp_w1", dut_xfer[1], 32'h08070605);
            chk("bp_w2", dut_xfer[2], 32'h0C0B0A09);
        end

        // Reset mid-word
        step(0, 1, 8'h01, 0, 1);
        step(0, 1, 8'h02, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        chk("mrst_valid", 32'(valid_post_o), 32'h0);
        chk("mrst_data",  data_post_o,       32'h0);
        chk("mrst_keep",  32'(keep_post_o),  32'h0);
        chk("mrst_last",  32'(last_post_o),  32'h0);
        step(0, 1, 8'hA1, 0, 1);
        step(0, 1, 8'hA2, 0, 1);
        step(0, 1, 8'hA3, 0, 1);
        step(0, 1, 8'hA4, 0, 1);
        chk("mrst_word", data_post_o,      32'hA4A3A2A1);
        chk("mrst_wkeep", 32'(keep_post_o), 32'hF);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));

`ifdef PACKER_STAT_EN
        step(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 65537; i++) step(0, 1, 8'(i), 1, 1);
        step(0, 0, 8'h00, 0, 1);
        chk("stat_wrap", 32'(stat_words_o), 32'h1);
        step(1, 0, 8'h00, 0, 0);
        chk("stat_rst", 32'(stat_words_o), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hs_byte_packer.md
Name: hs_byte_packer

Overview:
- Downstream neighbour of the 8-bit valid/ready register-slice stage.
- Consumes its byte stream and packs BEATS consecutive bytes into one wide word, little-endian.
- Emits each word on a registered valid/ready output toward the wide datapath.
- A per-byte last flag flushes a partial word early, with a byte-keep mask marking the valid lanes.

Parameters:
- BEATS, 4, bytes per output word; legal range 2..8.
- DW, 8, input byte width; fixed at 8. Output width is BEATS*DW.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_pre_i  in  1  byte valid from the upstream slice.
- data_pre_i  in  8  byte data.
- last_pre_i  in  1  marks the final byte of a packet; qualified by valid_pre_i.
- ready_pre_o  out  1  byte accepted when valid_pre_i & ready_pre_o.
- valid_post_o  out  1  word valid; registered.
- data_post_o  out  BEATS*8  packed word; byte k occupies bits [8k+7:8k]; registered.
- keep_post_o  out  BEATS  bit k=1 means lane k holds a real byte; registered.
- last_post_o  out  1  word ends a packet; registered.
- ready_post_i  in  1  word taken when valid_post_o & ready_post_i.
- stat_words_o  out  16  transferred-word count; present only with PACKER_STAT_EN.

Behaviour:
- Reset is synchronous and active-high on rst. Single clock clk; no other clock or reset.
- Reset values: valid_post_o=0, data_post_o=0, keep_post_o=0, last_post_o=0, byte index idx=0, accumulator acc=0, stat counter=0.
- Reset asserted mid-word discards all partially accumulated bytes. A word held in the output register at reset is dropped.
- Internal state:
  - acc: (BEATS-1)*8 bits, holds lanes 0..BEATS-2.
  - idx: byte index, 0..BEATS-1.
  - Output register: data, keep, last, valid.
- ready_pre_o = !valid_post_o | ready_post_i.
  - Combinational path from ready_post_i to ready_pre_o is intentional.
  - Gives full throughput when downstream is always ready.
- Accept, non-completing (idx<BEATS-1 and last_pre_i=0): acc lane idx <= data_pre_i; idx <= idx+1.
- Accept, completing (idx==BEATS-1 or last_pre_i=1):
  - data_post_o <= acc lanes 0..idx-1 merged with data_pre_i at lane idx; lanes above idx are zero.
  - keep_post_o <= (1<<(idx+1))-1.
  - last_post_o <= last_pre_i.
  - valid_post_o <= 1.
  - idx <= 0; acc <= 0.
- Latency: word is visible on the cycle after its final byte is accepted.
- Drain with no completion in the same cycle: valid_post_o <= 0. data, keep and last hold their values; do not clear them.
- Drain and completion in the same cycle: the new word loads and valid_post_o stays 1. No bubble.
- While valid_post_o=1 and ready_post_i=0, data/keep/last/valid stay stable (AXI-style hold).
- Stall rule: no input byte is accepted while the output is stalled. This includes non-completing bytes, because ready_pre_o=0.
- last_pre_i on the BEATS-th byte gives keep=all ones and last=1.
- last_pre_i on the first byte gives keep=...0001.
- valid_pre_i=0 leaves idx and acc unchanged. Packing has no timeout.
- idx wraps BEATS-1 -> 0 only through completion. It never exceeds BEATS-1.

Optional Feature:
- Macro: PACKER_STAT_EN.
- Defined:
  - 16-bit counter stat_words_o increments by 1 on every cycle with valid_post_o & ready_post_i.
  - Wraps 16'hFFFF -> 16'h0000.
  - Cleared by rst.
  - Port stat_words_o exists.
- Undefined: no counter and no stat_words_o port. All other behaviour is identical.

Test Plan:
- BEATS=4, ready_post_i=1, bytes 11,22,33,44 on consecutive cycles, last=0 -> one cycle after the 44 accept: valid_post_o=1, data_post_o=32'h44332211, keep=4'hF, last=0. ready_pre_o stays 1 throughout.
- Bytes AA, BB with last_pre_i=1 on BB -> data_post_o=32'h0000BBAA, keep=4'b0011, last=1. The next byte CC lands in lane 0.
- Single byte 5A with last=1 -> data=32'h0000005A, keep=4'b0001, last=1.
- Backpressure: ready_post_i=0 after first word 0x04030201 is emitted, source streams 05..0C ->
  - ready_pre_o=0 and outputs hold stable for the whole stall.
  - On release, words 0x08070605 then 0x0C0B0A09 arrive in order, none lost or duplicated.
- Accept 01,02 then pulse rst for 1 cycle, then send A1,A2,A3,A4 -> all outputs 0 after reset; next word=32'hA4A3A2A1, keep=4'hF (partial bytes discarded).
- PACKER_STAT_EN defined: transfer 65537 words with ready_post_i=1 -> stat_words_o=16'h0001. rst -> 16'h0000.
